// File: rtl/rat_irq_pkg.sv
// Shared types and helpers for the RAT vectored interrupt controller.
package rat_irq_pkg;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    localparam int PRIO_W = 16;

    function automatic int irq_id_w(input int n);
        return $clog2(n > 1 ? n : 2);
    endfunction

    // Lowest set index wins; an empty vector encodes as 0.
    function automatic logic [3:0] prio_enc(input logic [PRIO_W-1:0] v);
        prio_enc = '0;
        for (int i = PRIO_W - 1; i >= 0; i--)
            if (v[i]) prio_enc = 4'(i);
    endfunction

endpackage

// File: rtl/rat_irq_sync.sv
// One interrupt channel: 2-flop synchroniser plus optional rising-edge detect.
// evt is the synced level (EDGE=0) or a one-cycle rise pulse (EDGE=1).
module rat_irq_sync #(
    parameter bit EDGE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    output logic evt
);

    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], irq};
    end

    if (EDGE) begin : g_edge
        logic prev;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) prev <= 1'b0;
            else        prev <= sync[1];
        end
        assign evt = sync[1] & ~prev;
    end else begin : g_lvl
        assign evt = sync[1];
    end

endmodule

// File: rtl/rat_irq_ctrl.sv
// Vectored multi-channel interrupt controller for the RAT CPU; owns the I flag.
// Define RAT_IRQ_NEST_EN to allow higher-priority requests to nest over in-service ones.
module rat_irq_ctrl
    import rat_irq_pkg::*;
#(
    parameter int                 NUM_IRQ   = 8,
    parameter int                 ADDR_W    = 10,
    parameter logic [ADDR_W-1:0]  VEC_BASE  = ADDR_W'(10'h3F8),
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '1
) (
    input  logic                            CLK,
    input  logic                            RESET_N,
    input  logic [NUM_IRQ-1:0]              IRQ,
    input  logic                            I_SET,
    input  logic                            I_CLR,
    input  logic                            MASK_WE,
    input  logic [NUM_IRQ-1:0]              MASK_DIN,
    input  logic                            INTR_ACK,
    input  logic                            INTR_RET,
    output logic                            INTR_REQ,
    output logic [ADDR_W-1:0]               VECTOR,
    output logic [irq_id_w(NUM_IRQ)-1:0]    IRQ_ID,
    output logic                            I_FLAG,
    output logic [NUM_IRQ-1:0]              PENDING
);

    localparam int IDW = irq_id_w(NUM_IRQ);

    state_t             state, state_nxt;
    logic [NUM_IRQ-1:0] pend, mask, evt, act;
    logic [IDW-1:0]     id_q, win;
    logic               i_flag, can_req, id_masked, take;
    state_t             back_st, ret_st;

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
        rat_irq_sync #(.EDGE(EDGE_MASK[gi])) u_sync (
            .clk  (CLK),
            .rst_n(RESET_N),
            .irq  (IRQ[gi]),
            .evt  (evt[gi])
        );
    end

    assign act  = pend & mask;
    assign win  = IDW'(prio_enc(PRIO_W'(act)));
    assign take = (state == REQ) && INTR_ACK;
    // A mask write in the same cycle counts, so REQ drops right after the write.
    assign id_masked = MASK_WE ? ~MASK_DIN[id_q] : ~mask[id_q];

`ifdef RAT_IRQ_NEST_EN
    logic [NUM_IRQ-1:0] isr, isr_ret;
    logic [IDW-1:0]     isr_top;

    assign isr_top = IDW'(prio_enc(PRIO_W'(isr)));
    assign isr_ret = isr & ~(NUM_IRQ'(1) << isr_top);
    assign can_req = i_flag && (|act) && (~|isr || (win < isr_top));
    assign back_st = (|isr)     ? SERVICE : IDLE;
    assign ret_st  = (|isr_ret) ? SERVICE : IDLE;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                            isr <= '0;
        else if (take)                           isr[id_q] <= 1'b1;
        else if (state == SERVICE && INTR_RET)   isr <= isr_ret;
    end
`else
    assign can_req = i_flag && (|act) && (state == IDLE);
    assign back_st = IDLE;
    assign ret_st  = IDLE;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (can_req) state_nxt = REQ;
            REQ:     if (INTR_ACK)               state_nxt = SERVICE;
                     else if (I_CLR || id_masked) state_nxt = back_st;
            SERVICE: if (INTR_RET)     state_nxt = ret_st;
                     else if (can_req) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            id_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == REQ && state != REQ) id_q <= win;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mask   <= '0;
            i_flag <= 1'b0;
        end else begin
            if (MASK_WE) mask <= MASK_DIN;
            if (I_CLR || take) i_flag <= 1'b0;
            else if (I_SET)    i_flag <= 1'b1;
        end
    end

    // A fresh edge on the channel being acknowledged keeps it pending.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) pend <= '0;
        else begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (EDGE_MASK[i]) begin
                    if (evt[i])                           pend[i] <= 1'b1;
                    else if (take && id_q == IDW'(i))     pend[i] <= 1'b0;
                end else begin
                    pend[i] <= evt[i];
                end
            end
        end
    end

    assign INTR_REQ = (state == REQ);
    assign IRQ_ID   = id_q;
    assign VECTOR   = VEC_BASE + ADDR_W'(id_q);
    assign I_FLAG   = i_flag;
    assign PENDING  = pend;

endmodule

// File: tb/tb_rat_irq_ctrl.sv
// Bench for rat_irq_ctrl: vector table, directed corner sequences and a randomized
// run against a behavioural model (edge-sensitive instance, no nesting).
module tb_rat_irq_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] irq, mask_din;
    logic       i_set, i_clr, mask_we, ack, ret;

    logic       req_e, if_e, req_l, if_l;
    logic [9:0] vec_e, vec_l;
    logic [2:0] id_e, id_l;
    logic [7:0] pend_e, pend_l;

    int n_chk = 0, n_pass = 0;

    always #5 CLK = ~CLK;

    rat_irq_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N), .IRQ(irq), .I_SET(i_set), .I_CLR(i_clr),
        .MASK_WE(mask_we), .MASK_DIN(mask_din), .INTR_ACK(ack), .INTR_RET(ret),
        .INTR_REQ(req_e), .VECTOR(vec_e), .IRQ_ID(id_e), .I_FLAG(if_e), .PENDING(pend_e)
    );

    rat_irq_ctrl #(.EDGE_MASK(8'hFE)) dut_lvl (
        .CLK(CLK), .RESET_N(RESET_N), .IRQ(irq), .I_SET(i_set), .I_CLR(i_clr),
        .MASK_WE(mask_we), .MASK_DIN(mask_din), .INTR_ACK(ack), .INTR_RET(ret),
        .INTR_REQ(req_l), .VECTOR(vec_l), .IRQ_ID(id_l), .I_FLAG(if_l), .PENDING(pend_l)
    );

    typedef struct {
        logic [7:0] irq;
        logic       iset, iclr, mwe;
        logic [7:0] mdin;
        logic       ack, ret;
        logic       req;
        logic [9:0] vec;
        logic [2:0] id;
        logic       iflag;
        logic [7:0] pend;
    } vec_t;

    vec_t tbl[17];

    // behavioural model: history of sampled IRQ values, pending set, one mode word
    logic [7:0] m_pend, m_mask;
    bit         m_if;
    int         m_st, m_id;
    logic [7:0] m_hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic idle_in();
        irq = '0; i_set = 0; i_clr = 0; mask_we = 0; mask_din = '0; ack = 0; ret = 0;
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_if = 0; m_st = 0; m_id = 0;
        m_hist = '{8'h00, 8'h00, 8'h00};
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Applies the spec rules for the edge that just happened, using the inputs held across it.
    task automatic model_step();
        logic [7:0] rise, act, pend_n;
        int         st_n, id_n;
        bit         if_n;
        rise   = m_hist[1] & ~m_hist[2];
        act    = m_pend & m_mask;
        pend_n = m_pend | rise;
        st_n = m_st; id_n = m_id; if_n = m_if;
        case (m_st)
            0: if (m_if && act != 0) begin st_n = 1; id_n = lowest(act); end
            1: if (ack) begin
                   st_n = 2;
                   if (!rise[m_id]) pend_n[m_id] = 1'b0;
               end else if (i_clr || (mask_we ? !mask_din[m_id] : !m_mask[m_id])) st_n = 0;
            default: if (ret) st_n = 0;
        endcase
        if (i_clr || (m_st == 1 && ack)) if_n = 0;
        else if (i_set)                  if_n = 1;
        if (mask_we) m_mask = mask_din;
        m_pend = pend_n; m_st = st_n; m_id = id_n; m_if = if_n;
        m_hist.push_front(irq);
        void'(m_hist.pop_back());
    endtask

    task automatic do_reset();
        idle_in();
        RESET_N = 0;
        #3;
        check("reset_state", {req_e, vec_e, id_e, if_e, pend_e}, {1'b0, 10'h3F8, 3'd0, 1'b0, 8'h00});
        tick(); tick();
        RESET_N = 1;
        model_reset();
    endtask

    task automatic wait_req(input bit lvl, input int max, output bit got);
        got = 0;
        for (int k = 0; k < max && !got; k++) begin
            tick();
            got = lvl ? req_l : req_e;
        end
    endtask

    function automatic vec_t mk(input logic [7:0] i, input logic s, c, w, input logic [7:0] d,
                                input logic a, r, q, input logic [9:0] v, input logic [2:0] n,
                                input logic f, input logic [7:0] p);
        vec_t t;
        t.irq = i; t.iset = s; t.iclr = c; t.mwe = w; t.mdin = d; t.ack = a; t.ret = r;
        t.req = q; t.vec = v; t.id = n; t.iflag = f; t.pend = p;
        return t;
    endfunction

    initial begin
        bit got, seen;

        //            irq  set clr we  din  ack ret | req vec     id  if pend
        tbl[0]  = mk(8'h00, 1, 0, 1, 8'hFF, 0, 0,   0, 10'h3F8, 0, 1, 8'h00);
        tbl[1]  = mk(8'h08, 0, 0, 0, 8'h00, 0, 0,   0, 10'h3F8, 0, 1, 8'h00);
        tbl[2]  = mk(8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 10'h3F8, 0, 1, 8'h00);
        tbl[3]  = mk(8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 10'h3F8, 0, 1, 8'h08);
        tbl[4]  = mk(8'h00, 0, 0, 0, 8'h00, 0, 0,   1, 10'h3FB, 3, 1, 8'h08);
        tbl[5]  = mk(8'h00, 0, 0, 0, 8'h00, 1, 0,   0, 10'h3FB, 3, 0, 8'h00);
        tbl[6]  = mk(8'h00, 0, 0, 0, 8'h00, 0, 1,   0, 10'h3FB, 3, 0, 8'h00);
        tbl[7]  = mk(8'h24, 1, 0, 0, 8'h00, 0, 0,   0, 10'h3FB, 3, 1, 8'h00);
        tbl[8]  = mk(8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 10'h3FB, 3, 1, 8'h00);
        tbl[9]  = mk(8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 10'h3FB, 3, 1, 8'h24);
        tbl[10] = mk(8'h00, 0, 0, 0, 8'h00, 0, 0,   1, 10'h3FA, 2, 1, 8'h24);
        tbl[11] = mk(8'h00, 0, 0, 0, 8'h00, 1, 0,   0, 10'h3FA, 2, 0, 8'h20);
        tbl[12] = mk(8'h00, 0, 0, 0, 8'h00, 0, 1,   0, 10'h3FA, 2, 0, 8'h20);
        tbl[13] = mk(8'h00, 1, 0, 0, 8'h00, 0, 0,   0, 10'h3FA, 2, 1, 8'h20);
        tbl[14] = mk(8'h00, 0, 0, 0, 8'h00, 0, 0,   1, 10'h3FD, 5, 1, 8'h20);
        tbl[15] = mk(8'h00, 0, 0, 0, 8'h00, 1, 0,   0, 10'h3FD, 5, 0, 8'h00);
        tbl[16] = mk(8'h00, 0, 0, 0, 8'h00, 0, 1,   0, 10'h3FD, 5, 0, 8'h00);

        do_reset();

        // basic request, ack/ret, priority between two pending channels
        foreach (tbl[r]) begin
            irq = tbl[r].irq; i_set = tbl[r].iset; i_clr = tbl[r].iclr; mask_we = tbl[r].mwe;
            mask_din = tbl[r].mdin; ack = tbl[r].ack; ret = tbl[r].ret;
            tick();
            check($sformatf("tbl%0d", r), {req_e, vec_e, id_e, if_e, pend_e},
                  {tbl[r].req, tbl[r].vec, tbl[r].id, tbl[r].iflag, tbl[r].pend});
        end
        idle_in();

        // I flag off: request stays pending, I_SET releases it
        irq = 8'h01; tick(); irq = 8'h00;
        seen = 0;
        for (int k = 0; k < 5; k++) begin tick(); seen |= req_e; end
        check("iflag0_noreq", {seen, pend_e}, {1'b0, 8'h01});
        i_set = 1; tick(); got = req_e; i_set = 0;
        if (!got) begin tick(); got = req_e; end
        check("iset_req", {got, vec_e}, {1'b1, 10'h3F8});
        ack = 1; tick(); ack = 0; ret = 1; tick(); ret = 0;

        // level channel held through ACK
        do_reset();
        mask_we = 1; mask_din = 8'hFF; i_set = 1; tick(); idle_in();
        irq = 8'h01;
        wait_req(1, 8, got);
        check("lvl_req", {got, id_l}, {1'b1, 3'd0});
        ack = 1; tick(); ack = 0;
        check("lvl_ack_pend", {req_l, pend_l[0], if_l}, {1'b0, 1'b1, 1'b0});
        ret = 1; tick(); ret = 0;
        i_set = 1; tick(); i_set = 0;
        wait_req(1, 3, got);
        check("lvl_rereq", {got, vec_l}, {1'b1, 10'h3F8});
        irq = 8'h00; ack = 1; tick(); ack = 0; ret = 1; tick(); ret = 0;

        // masking the latched channel, I_CLR in REQ, SET/CLR collision, MASK_WE with ACK
        do_reset();
        mask_we = 1; mask_din = 8'hFF; i_set = 1; tick(); idle_in();
        irq = 8'h40; tick(); irq = 8'h00;
        wait_req(0, 8, got);
        check("m_req6", {got, id_e}, {1'b1, 3'd6});
        mask_we = 1; mask_din = 8'hBF; tick(); mask_we = 0;
        check("m_drop", req_e, 1'b0);
        tick(); tick();
        check("m_idle", {req_e, pend_e}, {1'b0, 8'h40});
        mask_we = 1; mask_din = 8'hFF; tick(); mask_we = 0;
        wait_req(0, 3, got);
        check("m_rereq", {got, vec_e}, {1'b1, 10'h3FE});
        i_clr = 1; tick(); i_clr = 0;
        check("iclr_drop", {req_e, if_e}, {1'b0, 1'b0});
        i_set = 1; i_clr = 1; tick(); i_set = 0; i_clr = 0;
        check("setclr_clr_wins", if_e, 1'b0);
        i_set = 1; tick(); i_set = 0;
        wait_req(0, 3, got);
        check("m_req_again", got, 1'b1);
        mask_we = 1; mask_din = 8'h00; ack = 1; tick(); mask_we = 0; ack = 0;
        check("mwe_ack", {req_e, if_e, pend_e, id_e}, {1'b0, 1'b0, 8'h00, 3'd6});
        ret = 1; tick(); ret = 0;

        // requests arriving while channel 5 is in service
        do_reset();
        mask_we = 1; mask_din = 8'hFF; i_set = 1; tick(); idle_in();
        irq = 8'h20; tick(); irq = 8'h00;
        wait_req(0, 8, got);
        check("s_req5", {got, id_e}, {1'b1, 3'd5});
        ack = 1; tick(); ack = 0;
        i_set = 1; tick(); i_set = 0;
        irq = 8'h40; tick(); irq = 8'h00;
        seen = 0;
        for (int k = 0; k < 5; k++) begin tick(); seen |= req_e; end
        check("s_no_req6", {seen, pend_e}, {1'b0, 8'h40});
        irq = 8'h02; tick(); irq = 8'h00;
`ifdef RAT_IRQ_NEST_EN
        wait_req(0, 6, got);
        check("n_req1", {got, vec_e}, {1'b1, 10'h3F9});
        ack = 1; tick(); ack = 0;
        ret = 1; tick(); ret = 0;
        i_set = 1; tick(); i_set = 0;
        irq = 8'h08; tick(); irq = 8'h00;
        wait_req(0, 6, got);
        check("n_req3_after_ret", {got, id_e}, {1'b1, 3'd3});
        ack = 1; tick(); ack = 0;
        ret = 1; tick(); ret = 1; tick(); ret = 0;
        i_set = 1; tick(); i_set = 0;
        wait_req(0, 3, got);
        check("n_req6_last", {got, id_e}, {1'b1, 3'd6});
`else
        seen = 0;
        for (int k = 0; k < 6; k++) begin tick(); seen |= req_e; end
        check("s_no_nest", seen, 1'b0);
        ret = 1; tick(); ret = 0;
        wait_req(0, 3, got);
        check("s_after_ret", {got, vec_e}, {1'b1, 10'h3F9});
`endif

        // reset in the middle of a transaction drops everything
        do_reset();

`ifndef RAT_IRQ_NEST_EN
        for (int n = 0; n < 2000; n++) begin
            irq      = 8'($urandom & $urandom & $urandom);
            i_set    = ($urandom_range(0, 2) == 0);
            i_clr    = ($urandom_range(0, 9) == 0);
            mask_we  = ($urandom_range(0, 11) == 0);
            mask_din = 8'($urandom);
            ack      = ($urandom_range(0, 2) == 0);
            ret      = ($urandom_range(0, 3) == 0);
            tick();
            model_step();
            check($sformatf("rnd%0d", n), {req_e, if_e, id_e, vec_e, pend_e},
                  {m_st == 1, m_if, 3'(m_id), 10'h3F8 + 10'(m_id), m_pend});
        end
        idle_in();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
